// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the posted-write store buffer
package store_buffer_pkg;

  typedef logic [31:0] regval_t;

  typedef struct packed {
    regval_t address;
    regval_t data;
  } store_entry_t;

  localparam logic [3:0] StoreByteEnable = 4'hF;

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - in-order entry storage with separate occupancy count
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  store_entry_t             entry,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output store_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t      mem [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[head_ptr];

  // Storage is not cleared on reset; the bus side gates it with the count.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[tail_ptr] <= entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) begin
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (pop_ok) begin
        head_ptr <= head_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer draining stores to an Avalon-MM style bus
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     address_enable,
  input  regval_t                  address,
  input  regval_t                  data,
  output logic                     data_valid,
  output logic [31:0]              avm_address,
  output logic [31:0]              avm_writedata,
  output logic [3:0]               avm_byteenable,
  output logic                     avm_write,
  input  logic                     avm_waitrequest,
  output logic                     drained,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     bus_error
);

  localparam logic [16:0] TimeoutLimit = 17'(TIMEOUT);

  store_entry_t new_entry;
  store_entry_t head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [15:0]  wait_count;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  // No bypass when full: a pop in the same cycle does not make room yet.
  assign push       = address_enable && !reset && !full;
  assign data_valid = push;
  assign new_entry  = '{address: {address[31:2], 2'b00}, data: data};

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .entry (new_entry),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (occupancy)
  );

  assign avm_write      = !empty;
  assign pop            = avm_write && !avm_waitrequest;
  assign avm_address    = avm_write ? head.address : '0;
  assign avm_writedata  = avm_write ? head.data : '0;
  assign avm_byteenable = StoreByteEnable;
  assign drained        = empty;

  // Stall counter saturates; bus_error is sticky until reset and the head is retried.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count <= '0;
      bus_error  <= 1'b0;
    end else if (pop || empty) begin
      wait_count <= '0;
    end else if (avm_write && avm_waitrequest) begin
      if (wait_count != 16'hFFFF) begin
        wait_count <= wait_count + 16'd1;
      end
      if (({1'b0, wait_count} + 17'd1) >= TimeoutLimit) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  logic        clock;
  logic        reset;
  logic        address_enable;
  logic [31:0] address;
  logic [31:0] data;
  logic        data_valid;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_write;
  logic        avm_waitrequest;
  logic        drained;
  logic [2:0]  occupancy;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .address_enable  (address_enable),
    .address         (address),
    .data            (data),
    .data_valid      (data_valid),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest),
    .drained         (drained),
    .occupancy       (occupancy),
    .bus_error       (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    address_enable  = 1'b1;
    address         = 32'h0000_0040;
    data            = 32'h1111_1111;
    avm_waitrequest = 1'b0;

    // Reset held two cycles with a store presented
    for (int i = 0; i < 2; i++) begin
      settle();
      check("reset_dv", {31'd0, data_valid}, 32'd0);
      tick();
    end
    reset          = 1'b0;
    address_enable = 1'b0;
    settle();
    check("idle_write", {31'd0, avm_write}, 32'd0);
    check("idle_drained", {31'd0, drained}, 32'd1);
    check("idle_occ", {29'd0, occupancy}, 32'd0);
    check("idle_err", {31'd0, bus_error}, 32'd0);
    check("idle_addr", avm_address, 32'd0);
    check("idle_wdata", avm_writedata, 32'd0);
    tick();

    // Single store, bus ready
    address_enable = 1'b1;
    address        = 32'h0000_1007;
    data           = 32'hDEAD_BEEF;
    settle();
    check("single_dv", {31'd0, data_valid}, 32'd1);
    tick();
    address_enable = 1'b0;
    settle();
    check("single_write", {31'd0, avm_write}, 32'd1);
    check("single_addr", avm_address, 32'h0000_1004);
    check("single_wdata", avm_writedata, 32'hDEAD_BEEF);
    check("single_be", {28'd0, avm_byteenable}, 32'hF);
    check("single_occ", {29'd0, occupancy}, 32'd1);
    tick();
    settle();
    check("single_drained", {31'd0, drained}, 32'd1);
    check("single_nowrite", {31'd0, avm_write}, 32'd0);

    // Fill to full under stall
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      address_enable = 1'b1;
      address        = 32'h0000_0100 + 32'(i * 4);
      data           = 32'hA000_0000 + 32'(i);
      settle();
      check($sformatf("fill_dv%0d", i), {31'd0, data_valid}, (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    settle();
    check("fill_occ", {29'd0, occupancy}, 32'd4);
    check("fill_dv_hold", {31'd0, data_valid}, 32'd0);
    check("fill_err", {31'd0, bus_error}, 32'd0);
    avm_waitrequest = 1'b0;
    settle();
    check("full_pop_dv", {31'd0, data_valid}, 32'd0);
    check("drain_a0", avm_address, 32'h0000_0100);
    check("drain_a0_d", avm_writedata, 32'hA000_0000);
    tick();
    check("a4_accept_dv", {31'd0, data_valid}, 32'd1);
    check("a4_occ", {29'd0, occupancy}, 32'd3);
    check("drain_a1", avm_address, 32'h0000_0104);
    tick();
    address_enable = 1'b0;
    for (int i = 2; i < 5; i++) begin
      settle();
      check($sformatf("drain_a%0d", i), avm_address, 32'h0000_0100 + 32'(i * 4));
      check($sformatf("drain_a%0d_d", i), avm_writedata, 32'hA000_0000 + 32'(i));
      tick();
    end
    settle();
    check("fill_drained", {31'd0, drained}, 32'd1);

    // Simultaneous push and pop at occupancy 2
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      address_enable = 1'b1;
      address        = 32'h0000_0200 + 32'(i * 4);
      data           = 32'hB000_0000 + 32'(i);
      tick();
    end
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) begin
      address_enable = 1'b1;
      address        = 32'h0000_0200 + 32'((i + 2) * 4);
      data           = 32'hB000_0000 + 32'(i + 2);
      settle();
      check($sformatf("pp_dv%0d", i), {31'd0, data_valid}, 32'd1);
      check($sformatf("pp_occ%0d", i), {29'd0, occupancy}, 32'd2);
      check($sformatf("pp_d%0d", i), avm_writedata, 32'hB000_0000 + 32'(i));
      tick();
    end
    address_enable = 1'b0;
    for (int i = 6; i < 8; i++) begin
      settle();
      check($sformatf("pp_d%0d", i), avm_writedata, 32'hB000_0000 + 32'(i));
      check($sformatf("pp_a%0d", i), avm_address, 32'h0000_0200 + 32'(i * 4));
      tick();
    end
    settle();
    check("pp_drained", {31'd0, drained}, 32'd1);

    // Timeout with TIMEOUT=8
    check("to_err_before", {31'd0, bus_error}, 32'd0);
    avm_waitrequest = 1'b1;
    address_enable  = 1'b1;
    address         = 32'h0000_2002;
    data            = 32'hC0FF_EE00;
    tick();
    address_enable = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      settle();
      check($sformatf("to_addr%0d", s), avm_address, 32'h0000_2000);
      check($sformatf("to_wdata%0d", s), avm_writedata, 32'hC0FF_EE00);
      check($sformatf("to_err%0d", s), {31'd0, bus_error}, (s >= 9) ? 32'd1 : 32'd0);
      tick();
    end
    avm_waitrequest = 1'b0;
    settle();
    check("to_release_write", {31'd0, avm_write}, 32'd1);
    tick();
    check("to_done", {31'd0, drained}, 32'd1);
    tick();
    tick();
    check("to_sticky", {31'd0, bus_error}, 32'd1);

    // Reset mid-operation with three entries stalled
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address_enable = 1'b1;
      address        = 32'h0000_3000 + 32'(i * 4);
      data           = 32'hD000_0000 + 32'(i);
      tick();
    end
    address_enable = 1'b0;
    settle();
    check("rst_pre_occ", {29'd0, occupancy}, 32'd3);
    reset          = 1'b1;
    address_enable = 1'b1;
    settle();
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    tick();
    reset          = 1'b0;
    address_enable = 1'b0;
    settle();
    check("rst_write", {31'd0, avm_write}, 32'd0);
    check("rst_occ", {29'd0, occupancy}, 32'd0);
    check("rst_drained", {31'd0, drained}, 32'd1);
    check("rst_err", {31'd0, bus_error}, 32'd0);
    check("rst_addr", avm_address, 32'd0);
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_idle%0d", i), {31'd0, avm_write}, 32'd0);
    end
    address_enable = 1'b1;
    address        = 32'h0000_4000;
    data           = 32'hE000_0001;
    tick();
    address_enable = 1'b0;
    settle();
    check("post_rst_addr", avm_address, 32'h0000_4000);
    check("post_rst_wdata", avm_writedata, 32'hE000_0001);
    tick();
    check("post_rst_drained", {31'd0, drained}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer directly downstream of the write stage.
- Accepts store requests (address_enable/address/data) from the write stage and returns data_valid in the same cycle when it has room.
- Drains buffered stores in order to the data bus as Avalon-MM style word writes.
- Reports empty/drained status for load ordering, and flags a bus timeout.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- TIMEOUT, 255, max consecutive waitrequest cycles on one bus write before bus_error sets; 1..65535.

Ports:
- clock  input  1  single clock; all state on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- address_enable  input  1  write stage presents a store this cycle.
- address  input  regval_t (32)  store byte address; bits [1:0] ignored.
- data  input  regval_t (32)  store data word.
- data_valid  output  1  store accepted this cycle (combinational); write stage releases hold.
- avm_address  output  32  bus word address, byte-granular, bits [1:0] = 0.
- avm_writedata  output  32  bus write data.
- avm_byteenable  output  4  always 4'hF.
- avm_write  output  1  bus write request.
- avm_waitrequest  input  1  bus stall; transfer completes on avm_write && !avm_waitrequest.
- drained  output  1  buffer empty and no bus write outstanding.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- bus_error  output  1  sticky timeout flag.

Behaviour:
- Reset (sync, active-high):
  - Next edge clears head/tail pointers, count, timeout counter and bus_error.
  - Outputs after that edge: avm_write=0, avm_address=0, avm_writedata=0, drained=1, occupancy=0, bus_error=0.
  - data_valid is forced 0 while reset is high.
  - Reset mid-transfer discards all entries, including the head being presented. The bus is expected to tolerate write dropping.
- Accept:
  - push = address_enable && !reset && count < DEPTH.
  - data_valid = push, purely combinational from address_enable, reset and registered count; there is no path from avm_waitrequest.
  - Entry stored is {address[31:2],2'b00, data}.
  - When full, data_valid=0 and the write stage holds, even if a pop happens in the same cycle; there is no full-bypass.
  - Every cycle with address_enable=1 and room is a new store. The write stage advances after data_valid, so there is no duplicate-accept guard.
- Drain:
  - avm_write = (count > 0); avm_address/avm_writedata are driven from the head entry (registered storage).
  - pop = avm_write && !avm_waitrequest; head pointer advances on the edge.
  - Latency: a store accepted at edge N appears on the bus from cycle N+1 when the buffer was empty. There is no empty bypass.
  - Order is strictly FIFO.
  - Head outputs stay stable while avm_waitrequest=1, as the Avalon hold rule requires.
- Simultaneous push and pop: count unchanged, both pointers advance; at full this cannot occur because push is 0.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH; count is a separate register, range 0..DEPTH.
- drained = (count == 0). Loads from the data path must wait for drained=1 before issuing; no address comparison is done here.
- Timeout:
  - 16-bit counter increments each cycle with avm_write && avm_waitrequest.
  - Clears on pop or when count==0.
  - When the counter reaches TIMEOUT, bus_error sets and stays set until reset; the entry is still held and retried.
- States implied by count: EMPTY (0), PARTIAL, FULL (DEPTH); no separate FSM register.

Decomposition:
- Shared package:
  - regval_t (existing).
  - New store_entry_t packed struct {address, data}.
  - StoreByteEnable = 4'hF.
- One sub-module, store_fifo:
  - Parameterised DEPTH.
  - Storage array, pointers, count.
  - push/pop inputs; full/empty/head outputs.
- store_buffer wraps store_fifo with accept logic, bus mapping and the timeout counter.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles with address_enable=1.
  - Required: data_valid=0 throughout; after release avm_write=0, drained=1, occupancy=0, bus_error=0.
- Single store, bus ready:
  - Stimulus: address=32'h0000_1007, data=32'hDEAD_BEEF, waitrequest=0.
  - Required: data_valid=1 that cycle; next cycle avm_write=1, avm_address=32'h0000_1004, avm_writedata=32'hDEAD_BEEF, byteenable=4'hF; the cycle after, drained=1.
- Fill to full:
  - Stimulus: waitrequest=1, 5 back-to-back stores A0..A4 with DEPTH=4.
  - Required: data_valid=1 for A0..A3 and 0 for A4, occupancy=4. Drop waitrequest; bus sees A0,A1,A2,A3 in order, and A4 is accepted the cycle after the first pop lowers count to 3.
- Simultaneous push/pop:
  - Stimulus: occupancy=2, waitrequest=0, store every cycle for 6 cycles.
  - Required: occupancy stays 2, data_valid=1 each cycle, no reordering or loss.
- Timeout:
  - Stimulus: TIMEOUT=8, one store, waitrequest=1 for 10 cycles, then 0.
  - Required: bus_error rises when the counter reaches 8; avm_address/avm_writedata stay stable throughout; entry completes after release; bus_error stays 1 until reset.
- Reset mid-operation:
  - Stimulus: occupancy=3 with waitrequest=1, assert reset for 1 cycle.
  - Required: next cycle avm_write=0, occupancy=0, drained=1; no stale entry is ever presented afterwards.
